// File: rtl/mbi5153_line_tx.sv
// Line transmitter for a daisy chain of MBI5153 LED drivers: fetches one line of
// grayscale words from line RAM and shifts them out MSB first with data-latch pulses.
module mbi5153_line_tx #(
    parameter int NUM_CH_IC    = 16,
    parameter int NUM_IC_CHAIN = 4,
    parameter int GS_WIDTH     = 16,
    parameter int OFS_WIDTH    = $clog2(NUM_CH_IC * NUM_IC_CHAIN)
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic                 REQUEST,
    input  logic [GS_WIDTH-1:0]  RAM_DATA,
    output logic                 LINE_READY,
    output logic                 LINE_TX_DONE,
    output logic                 RAM_RD,
    output logic [OFS_WIDTH-1:0] RAM_ADDR_OFS,
    output logic                 SDI,
    output logic                 LE,
    output logic                 DCLK_EN
);

    localparam int NUM_WORDS = NUM_CH_IC * NUM_IC_CHAIN;
    localparam int BIT_W     = $clog2(GS_WIDTH);
    localparam int WORD_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int IC_W      = (NUM_IC_CHAIN > 1) ? $clog2(NUM_IC_CHAIN) : 1;

    localparam logic [BIT_W-1:0]     BIT_ZERO    = BIT_W'(0);
    localparam logic [BIT_W-1:0]     BIT_ONE     = BIT_W'(1);
    localparam logic [BIT_W-1:0]     BIT_LAST    = BIT_W'(GS_WIDTH - 1);
    localparam logic [BIT_W-1:0]     BIT_PRE_ARM = BIT_W'(GS_WIDTH - 3);
    localparam logic [WORD_W-1:0]    WORD_ZERO   = WORD_W'(0);
    localparam logic [WORD_W-1:0]    WORD_ONE    = WORD_W'(1);
    localparam logic [WORD_W-1:0]    WORD_LAST   = WORD_W'(NUM_WORDS - 1);
    localparam logic [IC_W-1:0]      IC_ZERO     = IC_W'(0);
    localparam logic [IC_W-1:0]      IC_ONE      = IC_W'(1);
    localparam logic [IC_W-1:0]      IC_LAST     = IC_W'(NUM_IC_CHAIN - 1);
    localparam logic [OFS_WIDTH-1:0] OFS_ZERO    = OFS_WIDTH'(0);
    localparam logic [OFS_WIDTH-1:0] OFS_FIRST   = OFS_WIDTH'(NUM_WORDS - 1);
    localparam logic [OFS_WIDTH-1:0] OFS_IC_STEP = OFS_WIDTH'(NUM_CH_IC);
    localparam logic [OFS_WIDTH-1:0] OFS_CH_STEP = OFS_WIDTH'((NUM_IC_CHAIN - 1) * NUM_CH_IC - 1);
    localparam logic [GS_WIDTH-1:0]  GS_ZERO     = GS_WIDTH'(0);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t                state_r, state_s;
    logic [BIT_W-1:0]      bit_r, bit_s;
    logic [WORD_W-1:0]     word_r, word_s;
    logic [IC_W-1:0]       ic_r, ic_s;
    logic [GS_WIDTH-1:0]   sr_r, sr_s;
    logic [OFS_WIDTH-1:0]  ofs_r, ofs_s;
    logic                  rd_r, rd_s;
    logic                  le_r, le_s;
    logic                  dclk_en_r, dclk_en_s;
    logic                  done_r, done_s;
    logic                  ready_r, ready_s;

    // Offset of the next word: the next IC toward the chain input, or after the
    // nearest IC the farthest IC one channel lower. Constant steps, no multiplier.
    function automatic logic [OFS_WIDTH-1:0] next_ofs(input logic [OFS_WIDTH-1:0] ofs,
                                                      input logic                 last_ic);
        logic [OFS_WIDTH-1:0] res;
        if (last_ic) begin
            res = ofs + OFS_CH_STEP;
        end else begin
            res = ofs - OFS_IC_STEP;
        end
        return res;
    endfunction

    // Next-state, counter, shift-register and output decode.
    always_comb begin
        state_s = state_r;
        bit_s   = bit_r;
        word_s  = word_r;
        ic_s    = ic_r;
        sr_s    = sr_r;
        ofs_s   = ofs_r;
        rd_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (REQUEST) begin
                    state_s = ST_FETCH;
                    ofs_s   = OFS_FIRST;
                    rd_s    = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                state_s = ST_WAIT;
                bit_s   = BIT_ZERO;
                word_s  = WORD_ZERO;
                ic_s    = IC_ZERO;
            end
            ST_WAIT: begin
                state_s = ST_SHIFT;
                sr_s    = RAM_DATA;
            end
            ST_SHIFT: begin
                if (bit_r == BIT_LAST) begin
                    bit_s = BIT_ZERO;
                    if (word_r == WORD_LAST) begin
                        state_s = ST_DONE;
                        sr_s    = GS_ZERO;
                    end else begin
                        word_s = word_r + WORD_ONE;
                        ic_s   = (ic_r == IC_LAST) ? IC_ZERO : (ic_r + IC_ONE);
                        sr_s   = RAM_DATA;
                    end
                end else begin
                    bit_s = bit_r + BIT_ONE;
                    sr_s  = {sr_r[GS_WIDTH-2:0], 1'b0};
                    // Arm the prefetch so its data arrives during the word's last bit.
                    if ((bit_r == BIT_PRE_ARM) && (word_r != WORD_LAST)) begin
                        rd_s  = 1'b1;
                        ofs_s = next_ofs(ofs_r, ic_r == IC_LAST);
                    end else begin
                        rd_s  = 1'b0;
                    end
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
                sr_s    = GS_ZERO;
            end
        endcase
        dclk_en_s = (state_s == ST_SHIFT);
        le_s      = (state_s == ST_SHIFT) && (bit_s == BIT_LAST) && (ic_s == IC_LAST);
        done_s    = (state_s == ST_DONE);
        ready_s   = (state_s == ST_IDLE);
    end

    // State, counters and registered outputs.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r   <= ST_IDLE;
            bit_r     <= BIT_ZERO;
            word_r    <= WORD_ZERO;
            ic_r      <= IC_ZERO;
            sr_r      <= GS_ZERO;
            ofs_r     <= OFS_ZERO;
            rd_r      <= 1'b0;
            le_r      <= 1'b0;
            dclk_en_r <= 1'b0;
            done_r    <= 1'b0;
            ready_r   <= 1'b1;
        end else begin
            state_r   <= state_s;
            bit_r     <= bit_s;
            word_r    <= word_s;
            ic_r      <= ic_s;
            sr_r      <= sr_s;
            ofs_r     <= ofs_s;
            rd_r      <= rd_s;
            le_r      <= le_s;
            dclk_en_r <= dclk_en_s;
            done_r    <= done_s;
            ready_r   <= ready_s;
        end
    end

    // The shift register MSB is the line bit; it is zero outside SHIFT.
    assign SDI          = sr_r[GS_WIDTH-1];
    assign LE           = le_r;
    assign DCLK_EN      = dclk_en_r;
    assign RAM_RD       = rd_r;
    assign RAM_ADDR_OFS = ofs_r;
    assign LINE_TX_DONE = done_r;
    assign LINE_READY   = ready_r;

endmodule

// File: tb/tb_mbi5153_line_tx.sv
// Directed bench for mbi5153_line_tx: default 4x16x16 chain with a RAM and chain
// model, plus a single-IC 4-bit instance for the small-geometry case.
module tb_mbi5153_line_tx;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        REQUEST;
    logic [15:0] RAM_DATA;
    logic        LINE_READY, LINE_TX_DONE, RAM_RD, SDI, LE, DCLK_EN;
    logic [5:0]  RAM_ADDR_OFS;

    logic        req_s;
    logic [3:0]  data_s;
    logic        ready_s, done_s, rd_s, sdi_s, le_s, dclk_s;
    logic [3:0]  ofs_s;

    always #5 CLK = ~CLK;

    mbi5153_line_tx u_dut (
        .CLK(CLK), .RESET_N(RESET_N), .REQUEST(REQUEST), .RAM_DATA(RAM_DATA),
        .LINE_READY(LINE_READY), .LINE_TX_DONE(LINE_TX_DONE), .RAM_RD(RAM_RD),
        .RAM_ADDR_OFS(RAM_ADDR_OFS), .SDI(SDI), .LE(LE), .DCLK_EN(DCLK_EN)
    );

    mbi5153_line_tx #(.NUM_CH_IC(16), .NUM_IC_CHAIN(1), .GS_WIDTH(4)) u_small (
        .CLK(CLK), .RESET_N(RESET_N), .REQUEST(req_s), .RAM_DATA(data_s),
        .LINE_READY(ready_s), .LINE_TX_DONE(done_s), .RAM_RD(rd_s),
        .RAM_ADDR_OFS(ofs_s), .SDI(sdi_s), .LE(le_s), .DCLK_EN(dclk_s)
    );

    int checks = 0;
    int failures = 0;
    int ram_mode = 0;
    logic [15:0] seed = 16'h0000;

    function automatic logic [15:0] ram_word(input logic [5:0] ofs);
        if (ram_mode == 0) return {10'd0, ofs};
        if (ofs == 6'd63) return 16'hA5C3;
        return {ofs, 4'h9, ofs} ^ seed;
    endfunction

    // RAM models: data valid one cycle after the read strobe
    always @(posedge CLK) if (RAM_RD) RAM_DATA <= ram_word(RAM_ADDR_OFS);
    always @(posedge CLK) if (rd_s) data_s <= ofs_s ^ 4'h5;

    // Chain model: four 16-bit shift registers; LE latches them into channel 15-grp
    logic [15:0] sreg [4];
    logic [15:0] latch [4][16];
    logic [3:0]  grp;
    always @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            grp <= 4'd0;
            for (int i = 0; i < 4; i++) sreg[i] <= 16'd0;
        end else if (DCLK_EN) begin
            sreg[0] <= {sreg[0][14:0], SDI};
            for (int i = 1; i < 4; i++) sreg[i] <= {sreg[i][14:0], sreg[i-1][15]};
            if (LE) begin
                latch[0][4'd15 - grp] <= {sreg[0][14:0], SDI};
                for (int i = 1; i < 4; i++) latch[i][4'd15 - grp] <= {sreg[i][14:0], sreg[i-1][15]};
                grp <= grp + 4'd1;
            end
        end
    end

    int rd_cyc_q[$];
    int rd_ofs_q[$];
    int first_sdi, last_sdi, dclk_n, le_n, le_bad, sdi_bad, done_n, done_cyc, ready_cyc, ready_bad;
    logic [6:0] rst_snap;

    // Drive one request at edge 0 and record what happens in cycles 1..budget.
    task automatic run_line(input bit hold, input int pulse_at, input int rst_at, input int budget);
        int idx;
        int rst_c;
        idx = 0; rst_c = -1;
        rd_cyc_q.delete(); rd_ofs_q.delete();
        first_sdi = -1; last_sdi = -1; done_cyc = -1; ready_cyc = -1;
        le_n = 0; le_bad = 0; sdi_bad = 0; done_n = 0; ready_bad = 0; rst_snap = 7'd0;
        @(negedge CLK); REQUEST = 1'b1;
        @(posedge CLK);
        for (int c = 1; c <= budget; c++) begin
            @(negedge CLK);
            if (!hold && c == 1) REQUEST = 1'b0;
            if (pulse_at > 0 && c == pulse_at) REQUEST = 1'b1;
            if (pulse_at > 0 && c == pulse_at + 1) REQUEST = 1'b0;
            if (rst_c >= 0 && c == rst_c + 5) RESET_N = 1'b1;
            if (RAM_RD) begin rd_cyc_q.push_back(c); rd_ofs_q.push_back(int'(RAM_ADDR_OFS)); end
            if (LINE_TX_DONE) begin done_n++; if (done_cyc < 0) done_cyc = c; end
            if (LINE_READY) begin
                if (done_cyc >= 0 && ready_cyc < 0) ready_cyc = c;
                if (done_cyc < 0 && rst_at < 0) ready_bad++;
            end
            if (DCLK_EN) begin
                if (first_sdi < 0) first_sdi = c;
                last_sdi = c;
                if (LE) begin le_n++; if (idx % 64 != 63) le_bad++; end
                if (rst_at >= 0 && idx == rst_at) begin
                    RESET_N = 1'b0; rst_c = c;
                    #1;
                    rst_snap = {SDI, LE, DCLK_EN, RAM_RD, LINE_TX_DONE, RAM_ADDR_OFS != 6'd0, LINE_READY};
                end
                idx++;
            end else begin
                if (LE) le_bad++;
                if (SDI) sdi_bad++;
            end
        end
        dclk_n = idx;
    endtask

    task automatic test_reset();
        RESET_N = 1'b0; REQUEST = 1'b0; req_s = 1'b0;
        repeat (3) @(negedge CLK);
        checks++; if (LINE_READY !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", LINE_READY); end
        checks++; if ({SDI, LE, DCLK_EN, RAM_RD, LINE_TX_DONE} !== 5'b0) begin failures++; $display("FAIL rst_outs got=%b exp=00000", {SDI, LE, DCLK_EN, RAM_RD, LINE_TX_DONE}); end
        checks++; if (RAM_ADDR_OFS !== 6'd0) begin failures++; $display("FAIL rst_ofs got=%0d exp=0", RAM_ADDR_OFS); end
        RESET_N = 1'b1;
        repeat (2) @(negedge CLK);
        checks++; if ({LINE_READY, DCLK_EN, RAM_RD} !== 3'b100) begin failures++; $display("FAIL idle_after_rst got=%b exp=100", {LINE_READY, DCLK_EN, RAM_RD}); end
    endtask

    task automatic test_basic();
        int bad_ofs, bad_pf, bad_chain, exp;
        ram_mode = 0;
        run_line(1'b0, 0, -1, 1040);
        checks++; if (rd_cyc_q.size() !== 64) begin failures++; $display("FAIL rd_count got=%0d exp=64", rd_cyc_q.size()); end
        checks++; if (rd_cyc_q[0] !== 1) begin failures++; $display("FAIL first_rd_cycle got=%0d exp=1", rd_cyc_q[0]); end
        checks++; if (rd_ofs_q[0] !== 63) begin failures++; $display("FAIL first_ofs got=%0d exp=63", rd_ofs_q[0]); end
        checks++; if (first_sdi !== 3) begin failures++; $display("FAIL first_sdi got=%0d exp=3", first_sdi); end
        checks++; if (last_sdi !== 1026) begin failures++; $display("FAIL last_sdi got=%0d exp=1026", last_sdi); end
        checks++; if (dclk_n !== 1024) begin failures++; $display("FAIL dclk_count got=%0d exp=1024", dclk_n); end
        checks++; if (done_n !== 1 || done_cyc !== 1027) begin failures++; $display("FAIL done got=%0d@%0d exp=1@1027", done_n, done_cyc); end
        checks++; if (ready_cyc !== 1028) begin failures++; $display("FAIL ready_cycle got=%0d exp=1028", ready_cyc); end
        checks++; if (ready_bad !== 0) begin failures++; $display("FAIL ready_busy got=%0d exp=0", ready_bad); end
        checks++; if (sdi_bad !== 0) begin failures++; $display("FAIL sdi_idle got=%0d exp=0", sdi_bad); end
        checks++; if (le_n !== 16 || le_bad !== 0) begin failures++; $display("FAIL le got=%0d/%0d exp=16/0", le_n, le_bad); end
        bad_ofs = 0; bad_pf = 0;
        for (int w = 0; w < 64 && w < rd_ofs_q.size(); w++) begin
            exp = (3 - (w % 4)) * 16 + (15 - w / 4);
            if (rd_ofs_q[w] != exp) bad_ofs++;
            if (w > 0 && rd_cyc_q[w] != 16 * w + 1) bad_pf++;
        end
        checks++; if (bad_ofs !== 0) begin failures++; $display("FAIL ofs_seq got=%0d bad exp=0", bad_ofs); end
        checks++; if (bad_pf !== 0) begin failures++; $display("FAIL prefetch_cycle got=%0d bad exp=0", bad_pf); end
        bad_chain = 0;
        for (int ic = 0; ic < 4; ic++) for (int ch = 0; ch < 16; ch++)
            if (latch[ic][ch] !== ram_word(6'(ic * 16 + ch))) bad_chain++;
        checks++; if (bad_chain !== 0) begin failures++; $display("FAIL chain_ofs_data got=%0d bad exp=0", bad_chain); end
    endtask

    task automatic test_serial();
        int bad_chain;
        ram_mode = 1; seed = 16'h5A5A;
        run_line(1'b0, 0, -1, 1040);
        checks++; if (latch[3][15] !== 16'hA5C3) begin failures++; $display("FAIL ic3_ch15 got=%h exp=a5c3", latch[3][15]); end
        checks++; if (latch[0][0] !== ram_word(6'd0)) begin failures++; $display("FAIL ic0_ch0 got=%h exp=%h", latch[0][0], ram_word(6'd0)); end
        bad_chain = 0;
        for (int ic = 0; ic < 4; ic++) for (int ch = 0; ch < 16; ch++)
            if (latch[ic][ch] !== ram_word(6'(ic * 16 + ch))) bad_chain++;
        checks++; if (bad_chain !== 0) begin failures++; $display("FAIL chain_pattern got=%0d bad exp=0", bad_chain); end
    endtask

    task automatic test_request_ignored();
        ram_mode = 1; seed = 16'h1234;
        run_line(1'b0, 100, -1, 1040);
        checks++; if (done_n !== 1) begin failures++; $display("FAIL ignored_done got=%0d exp=1", done_n); end
        checks++; if (rd_cyc_q.size() !== 64) begin failures++; $display("FAIL ignored_rd got=%0d exp=64", rd_cyc_q.size()); end
        checks++; if (dclk_n !== 1024) begin failures++; $display("FAIL ignored_dclk got=%0d exp=1024", dclk_n); end
    endtask

    task automatic test_back_to_back();
        bit got;
        int bad_chain;
        ram_mode = 1; seed = 16'hC0DE;
        run_line(1'b1, 0, -1, 1035);
        REQUEST = 1'b0;
        checks++; if (done_cyc !== 1027) begin failures++; $display("FAIL b2b_done got=%0d exp=1027", done_cyc); end
        checks++; if (rd_cyc_q.size() < 65 || rd_cyc_q[64] !== 1029) begin failures++; $display("FAIL b2b_second_rd got=%0d exp=1029", rd_cyc_q.size() > 64 ? rd_cyc_q[64] : -1); end
        checks++; if (rd_ofs_q.size() < 65 || rd_ofs_q[64] !== 63) begin failures++; $display("FAIL b2b_second_ofs got=%0d exp=63", rd_ofs_q.size() > 64 ? rd_ofs_q[64] : -1); end
        got = 1'b0;
        for (int c = 0; c < 1100 && !got; c++) begin
            @(negedge CLK);
            if (LINE_TX_DONE) got = 1'b1;
        end
        checks++; if (got !== 1'b1) begin failures++; $display("FAIL b2b_second_done got=%b exp=1", got); end
        bad_chain = 0;
        for (int ic = 0; ic < 4; ic++) for (int ch = 0; ch < 16; ch++)
            if (latch[ic][ch] !== ram_word(6'(ic * 16 + ch))) bad_chain++;
        checks++; if (bad_chain !== 0) begin failures++; $display("FAIL b2b_chain got=%0d bad exp=0", bad_chain); end
    endtask

    task automatic test_reset_mid();
        int bad_chain;
        ram_mode = 1; seed = 16'h3C5A;
        run_line(1'b0, 0, 500, 1040);
        checks++; if (rst_snap !== 7'b0000001) begin failures++; $display("FAIL midrst_outs got=%b exp=0000001", rst_snap); end
        checks++; if (done_n !== 0) begin failures++; $display("FAIL midrst_done got=%0d exp=0", done_n); end
        seed = 16'h0F0F;
        run_line(1'b0, 0, -1, 1040);
        checks++; if (done_cyc !== 1027 || dclk_n !== 1024) begin failures++; $display("FAIL after_rst_line got=%0d/%0d exp=1027/1024", done_cyc, dclk_n); end
        checks++; if (rd_ofs_q[0] !== 63) begin failures++; $display("FAIL after_rst_ofs got=%0d exp=63", rd_ofs_q[0]); end
        bad_chain = 0;
        for (int ic = 0; ic < 4; ic++) for (int ch = 0; ch < 16; ch++)
            if (latch[ic][ch] !== ram_word(6'(ic * 16 + ch))) bad_chain++;
        checks++; if (bad_chain !== 0) begin failures++; $display("FAIL after_rst_chain got=%0d bad exp=0", bad_chain); end
    endtask

    task automatic test_small();
        int idx, first, last, le_cnt, le_wrong, bit_bad, ofs_bad, rd_n, done_at, rdy_at;
        logic [3:0] d;
        idx = 0; first = -1; last = -1; le_cnt = 0; le_wrong = 0; bit_bad = 0;
        ofs_bad = 0; rd_n = 0; done_at = -1; rdy_at = -1;
        @(negedge CLK); req_s = 1'b1;
        @(posedge CLK);
        for (int c = 1; c <= 80; c++) begin
            @(negedge CLK);
            if (c == 1) req_s = 1'b0;
            if (rd_s) begin if (int'(ofs_s) != 15 - rd_n) ofs_bad++; rd_n++; end
            if (done_s && done_at < 0) done_at = c;
            if (ready_s && done_at >= 0 && rdy_at < 0) rdy_at = c;
            if (dclk_s) begin
                if (first < 0) first = c;
                last = c;
                d = 4'(15 - idx / 4) ^ 4'h5;
                if (sdi_s !== d[3 - idx % 4]) bit_bad++;
                if (le_s) begin le_cnt++; if (idx % 4 != 3) le_wrong++; end
                idx++;
            end else if (le_s || sdi_s) begin
                le_wrong++;
            end
        end
        checks++; if (idx !== 64 || first !== 3 || last !== 66) begin failures++; $display("FAIL small_shift got=%0d@%0d..%0d exp=64@3..66", idx, first, last); end
        checks++; if (le_cnt !== 16 || le_wrong !== 0) begin failures++; $display("FAIL small_le got=%0d/%0d exp=16/0", le_cnt, le_wrong); end
        checks++; if (rd_n !== 16 || ofs_bad !== 0) begin failures++; $display("FAIL small_ofs got=%0d/%0d exp=16/0", rd_n, ofs_bad); end
        checks++; if (bit_bad !== 0) begin failures++; $display("FAIL small_sdi got=%0d bad exp=0", bit_bad); end
        checks++; if (done_at !== 67 || rdy_at !== 68) begin failures++; $display("FAIL small_done got=%0d/%0d exp=67/68", done_at, rdy_at); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_serial();
        test_request_ignored();
        test_back_to_back();
        test_reset_mid();
        test_small();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
